// File: rtl/wb_tgt_mem.sv
// -----------------------------------------------------------------------------
// wb_tgt_mem
//   Pipelined Wishbone target in front of a byte-writable memory of
//   2**MEM_AW words. Every accepted request travels a LATENCY-deep
//   {valid, err, data} pipeline. It terminates with ack (in-range address)
//   or err (out-of-range address) exactly LATENCY cycles after acceptance.
//   An outstanding counter limits in-flight requests to MAX_OUT.
//
//   Optional feature: define WB_TGT_MEM_RAND_STALL_EN to add pseudo-random
//   stall cycles. They come from an 8-bit Fibonacci LFSR.
//
// Ports
//   clk_i         : clock
//   sync_rst_n_i  : synchronous reset, active low
//   tgt_cyc_i     : bus cycle indicator; low aborts all in-flight responses
//   tgt_stb_i     : access request
//   tgt_we_i      : write enable
//   tgt_sel_i     : byte selects
//   tgt_adr_i     : word address
//   tgt_dat_i     : write data
//   tgt_ack_o     : normal termination
//   tgt_err_o     : error termination (address outside the memory)
//   tgt_rty_o     : retry, always 0
//   tgt_stall_o   : request cannot be accepted this cycle (combinational)
//   tgt_dat_o     : read data, 0 unless a read is being acknowledged
// -----------------------------------------------------------------------------
module wb_tgt_mem #(
   parameter int ADR_WIDTH = 16,
   parameter int DAT_WIDTH = 16,   // must equal 8*SEL_WIDTH
   parameter int SEL_WIDTH = 2,
   parameter int MEM_AW    = 8,
   parameter int LATENCY   = 2,    // 1..8
   parameter int MAX_OUT   = 2     // 1..LATENCY
) (
   input  logic                 clk_i,
   input  logic                 sync_rst_n_i,
   input  logic                 tgt_cyc_i,
   input  logic                 tgt_stb_i,
   input  logic                 tgt_we_i,
   input  logic [SEL_WIDTH-1:0] tgt_sel_i,
   input  logic [ADR_WIDTH-1:0] tgt_adr_i,
   input  logic [DAT_WIDTH-1:0] tgt_dat_i,
   output logic                 tgt_ack_o,
   output logic                 tgt_err_o,
   output logic                 tgt_rty_o,
   output logic                 tgt_stall_o,
   output logic [DAT_WIDTH-1:0] tgt_dat_o
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [DAT_WIDTH-1:0] r_mem [2**MEM_AW];
   logic                 r_vld [LATENCY];
   logic                 r_err [LATENCY];
   logic [DAT_WIDTH-1:0] r_dat [LATENCY];
   logic [CNT_W-1:0]     r_cnt;

   logic              w_term;
   logic              w_acc;
   logic              w_stall;
   logic              w_rand;
   logic              w_adr_bad;
   logic [MEM_AW-1:0] w_idx;

   // A response at the pipeline tail terminates only inside a live bus cycle
   // and outside reset. An aborted cycle or a reset discards it silently.
   assign w_term    = sync_rst_n_i & tgt_cyc_i & r_vld[LATENCY-1];
   assign w_adr_bad = |(tgt_adr_i >> MEM_AW);
   assign w_idx     = tgt_adr_i[MEM_AW-1:0];

`ifdef WB_TGT_MEM_RAND_STALL_EN
   logic [7:0] r_lfsr;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1. It advances every non-reset cycle.
   always_ff @(posedge clk_i) begin
      if (!sync_rst_n_i) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_rand = r_lfsr[0];
`else
   assign w_rand = 1'b0;
`endif

   // A full counter blocks new requests, unless a slot frees up in this same cycle.
   assign w_stall = sync_rst_n_i & (((r_cnt == CNT_W'(MAX_OUT)) & ~w_term) | w_rand);
   assign w_acc   = sync_rst_n_i & tgt_cyc_i & tgt_stb_i & ~w_stall;

   // NOTE: memory arrays carry no reset; contents survive reset and bus aborts.
   always_ff @(posedge clk_i) begin
      if (w_acc && !w_adr_bad && tgt_we_i) begin
         for (int b = 0; b < SEL_WIDTH; b++) begin
            if (tgt_sel_i[b]) begin
               r_mem[w_idx][8*b +: 8] <= tgt_dat_i[8*b +: 8];
            end
         end
      end
   end

   // Valid bits and the counter are the only state that needs clearing.
   // NOTE: sequential state uses non-blocking assignments, so the shift reads pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!sync_rst_n_i || !tgt_cyc_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i] <= 1'b0;
         end
         r_cnt <= '0;
      end else begin
         r_vld[0] <= w_acc;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
         case ({w_acc, w_term})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Payload stages are qualified by r_vld and need no reset. Writes and errors
   // carry zero data, so tgt_dat_o stays 0 for them.
   always_ff @(posedge clk_i) begin
      r_err[0] <= w_adr_bad;
      r_dat[0] <= (!w_adr_bad && !tgt_we_i) ? r_mem[w_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
         r_err[i] <= r_err[i-1];
         r_dat[i] <= r_dat[i-1];
      end
   end

   assign tgt_ack_o   = w_term & ~r_err[LATENCY-1];
   assign tgt_err_o   = w_term &  r_err[LATENCY-1];
   assign tgt_rty_o   = 1'b0;
   assign tgt_stall_o = w_stall;
   assign tgt_dat_o   = tgt_ack_o ? r_dat[LATENCY-1] : '0;

endmodule
